// File: rtl/interconnect_sfft_to_n_data.sv
// Re-presents a shared sub-FFT's serial output (NCH sub-transforms back to back) as NCH parallel streams.
// Frames are buffered (one or two banks of NFFT samples) and leave strictly in arrival order.
module interconnect_sfft_to_n_data #(
    parameter int SIZE_BUFFER   = 4,
    parameter int LOG_CHANNELS  = 2,
    parameter int DATA_FFT_SIZE = 16,
    parameter int DOUBLE_BUF    = 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            fft_valid,
    input  logic [DATA_FFT_SIZE-1:0]                        data_from_fft_i,
    input  logic [DATA_FFT_SIZE-1:0]                        data_from_fft_q,
    output logic                                            resiveFromSecond,
    input  logic [(1<<LOG_CHANNELS)-1:0]                    flag_ready_recive,
    output logic [(1<<LOG_CHANNELS)*DATA_FFT_SIZE-1:0]      data_fft_i,
    output logic [(1<<LOG_CHANNELS)*DATA_FFT_SIZE-1:0]      data_fft_q,
    output logic [(1<<LOG_CHANNELS)-1:0]                    complete,
    output logic                                            overflow
);
    localparam int NFFT = 1 << SIZE_BUFFER;
    localparam int NCH  = 1 << LOG_CHANNELS;
    localparam int AW   = SIZE_BUFFER - LOG_CHANNELS;
    localparam int DW   = DATA_FFT_SIZE;

    typedef enum logic {W_FILL, W_BLOCKED} w_state_t;
    typedef enum logic {R_IDLE, R_STREAM} r_state_t;

    w_state_t               w_state;
    r_state_t               r_state;
    logic [SIZE_BUFFER-1:0] wc;
    logic [AW-1:0]          rc;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             full;

    // Storage is addressed {buffer, wc}; wc's top bits already select the channel bank.
    logic [DW-1:0] mem_i [2*NFFT];
    logic [DW-1:0] mem_q [2*NFFT];

    logic       accept;
    logic       wrap;
    logic       release_buf;
    logic       wr_ptr_next;
    logic [1:0] full_held;

    always_comb begin
        accept      = fft_valid && (w_state == W_FILL);
        wrap        = accept && (&wc);
        release_buf = (r_state == R_STREAM) && (&rc);
        wr_ptr_next = (wrap && DOUBLE_BUF != 0) ? ~wr_ptr : wr_ptr;
        full_held   = full;
        if (wrap)
            full_held[wr_ptr] = 1'b1;
    end

    // A buffer freed this edge is deliberately not seen until the next one, so the
    // write side reopens one cycle after the stream ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            wc               <= '0;
            wr_ptr           <= 1'b0;
            w_state          <= W_FILL;
            resiveFromSecond <= 1'b1;
            overflow         <= 1'b0;
        end else begin
            case (w_state)
                W_FILL:    if (accept) wc <= wc + 1'b1;
                W_BLOCKED: if (fft_valid) overflow <= 1'b1;
                default:   ;
            endcase
            wr_ptr <= wr_ptr_next;
            if (full_held[wr_ptr_next]) begin
                w_state          <= W_BLOCKED;
                resiveFromSecond <= 1'b0;
            end else begin
                w_state          <= W_FILL;
                resiveFromSecond <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
        end else begin
            full <= full_held;
            if (release_buf)
                full[rd_ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_i[{wr_ptr, wc}] <= data_from_fft_i;
            mem_q[{wr_ptr, wc}] <= data_from_fft_q;
        end
    end

    // Read side: all channels step together; ready is only consulted before a stream starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            rc         <= '0;
            rd_ptr     <= 1'b0;
            complete   <= '0;
            data_fft_i <= '0;
            data_fft_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    complete   <= '0;
                    data_fft_i <= '0;
                    data_fft_q <= '0;
                    if (full[rd_ptr] && (&flag_ready_recive)) begin
                        r_state <= R_STREAM;
                        rc      <= '0;
                    end
                end
                R_STREAM: begin
                    complete <= '1;
                    for (int c = 0; c < NCH; c++) begin
                        data_fft_i[c*DW +: DW] <= mem_i[{rd_ptr, LOG_CHANNELS'(c), rc}];
                        data_fft_q[c*DW +: DW] <= mem_q[{rd_ptr, LOG_CHANNELS'(c), rc}];
                    end
                    rc <= rc + 1'b1;
                    if (&rc) begin
                        r_state <= R_IDLE;
                        if (DOUBLE_BUF != 0)
                            rd_ptr <= ~rd_ptr;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interconnect_sfft_to_n_data.sv
// Directed bench for interconnect_sfft_to_n_data: four instances cover double/single buffering
// and the 2- and 8-channel splits of a 32-point frame.
module tb_interconnect_sfft_to_n_data;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  vld;
    logic [15:0] din_i, din_q;

    logic        rsv_db, ovf_db, rsv_sb, ovf_sb, rsv_c1, ovf_c1, rsv_c3, ovf_c3;
    logic [3:0]  rdy_db, rdy_sb, cpl_db, cpl_sb;
    logic [1:0]  rdy_c1, cpl_c1;
    logic [7:0]  rdy_c3, cpl_c3;
    logic [63:0] di_db, dq_db, di_sb, dq_sb;
    logic [31:0] di_c1, dq_c1;
    logic [127:0] di_c3, dq_c3;

    int n_pass = 0;
    int n_total = 0;
    logic blocked_seen;
    logic [31:0] cap_d [8][32];
    logic [7:0]  cap_c [32];
    int cap_n, cap_wait;

    always #5 clk = ~clk;

    interconnect_sfft_to_n_data #(.SIZE_BUFFER(4), .LOG_CHANNELS(2), .DATA_FFT_SIZE(16), .DOUBLE_BUF(1)) u_db (
        .clk(clk), .reset(reset), .fft_valid(vld[0]), .data_from_fft_i(din_i), .data_from_fft_q(din_q),
        .resiveFromSecond(rsv_db), .flag_ready_recive(rdy_db), .data_fft_i(di_db), .data_fft_q(dq_db),
        .complete(cpl_db), .overflow(ovf_db));
    interconnect_sfft_to_n_data #(.SIZE_BUFFER(4), .LOG_CHANNELS(2), .DATA_FFT_SIZE(16), .DOUBLE_BUF(0)) u_sb (
        .clk(clk), .reset(reset), .fft_valid(vld[1]), .data_from_fft_i(din_i), .data_from_fft_q(din_q),
        .resiveFromSecond(rsv_sb), .flag_ready_recive(rdy_sb), .data_fft_i(di_sb), .data_fft_q(dq_sb),
        .complete(cpl_sb), .overflow(ovf_sb));
    interconnect_sfft_to_n_data #(.SIZE_BUFFER(5), .LOG_CHANNELS(1), .DATA_FFT_SIZE(16), .DOUBLE_BUF(0)) u_c1 (
        .clk(clk), .reset(reset), .fft_valid(vld[2]), .data_from_fft_i(din_i), .data_from_fft_q(din_q),
        .resiveFromSecond(rsv_c1), .flag_ready_recive(rdy_c1), .data_fft_i(di_c1), .data_fft_q(dq_c1),
        .complete(cpl_c1), .overflow(ovf_c1));
    interconnect_sfft_to_n_data #(.SIZE_BUFFER(5), .LOG_CHANNELS(3), .DATA_FFT_SIZE(16), .DOUBLE_BUF(0)) u_c3 (
        .clk(clk), .reset(reset), .fft_valid(vld[3]), .data_from_fft_i(din_i), .data_from_fft_q(din_q),
        .resiveFromSecond(rsv_c3), .flag_ready_recive(rdy_c3), .data_fft_i(di_c3), .data_fft_q(dq_c3),
        .complete(cpl_c3), .overflow(ovf_c3));

    function automatic int nch(input int sel);
        case (sel)
            2:       return 2;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [7:0] cpl(input int sel);
        case (sel)
            0:       return {4'b0, cpl_db};
            1:       return {4'b0, cpl_sb};
            2:       return {6'b0, cpl_c1};
            default: return cpl_c3;
        endcase
    endfunction

    function automatic logic rsv(input int sel);
        case (sel)
            0:       return rsv_db;
            1:       return rsv_sb;
            2:       return rsv_c1;
            default: return rsv_c3;
        endcase
    endfunction

    function automatic logic [31:0] dat(input int sel, input int c);
        case (sel)
            0:       return {di_db[c*16 +: 16], dq_db[c*16 +: 16]};
            1:       return {di_sb[c*16 +: 16], dq_sb[c*16 +: 16]};
            2:       return {di_c1[c*16 +: 16], dq_c1[c*16 +: 16]};
            default: return {di_c3[c*16 +: 16], dq_c3[c*16 +: 16]};
        endcase
    endfunction

    // Sample k of a frame carries I = base+k, Q = ~I; drives happen on the falling edge.
    task automatic send(input int sel, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rsv(sel) == 1'b0) blocked_seen = 1'b1;
            vld      = 4'b0;
            vld[sel] = 1'b1;
            din_i    = 16'(base + k);
            din_q    = ~16'(base + k);
        end
        @(negedge clk);
        vld = 4'b0;
    endtask

    // Records one stream; cap_wait counts falling edges skipped before the first valid beat.
    task automatic capture(input int sel, input int maxwait);
        cap_n    = 0;
        cap_wait = -1;
        for (int w = 0; w < maxwait; w++) begin
            @(negedge clk);
            if (cpl(sel) != 8'h00) begin
                cap_wait = w;
                break;
            end
        end
        if (cap_wait >= 0) begin
            while (cpl(sel) != 8'h00 && cap_n < 32) begin
                cap_c[cap_n] = cpl(sel);
                for (int c = 0; c < nch(sel); c++) cap_d[c][cap_n] = dat(sel, c);
                cap_n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; vld = 4'b0; din_i = '0; din_q = '0;
        rdy_db = 4'hF; rdy_sb = 4'hF; rdy_c1 = 2'b11; rdy_c3 = 8'hFF;
        repeat (3) @(negedge clk);
        n_total++; if (rsv_db !== 1'b1) $display("FAIL reset_rsv got %b exp 1", rsv_db); else n_pass++;
        n_total++; if (cpl_db !== 4'h0) $display("FAIL reset_cpl got %h exp 0", cpl_db); else n_pass++;
        n_total++; if (di_db !== 64'h0 || dq_db !== 64'h0) $display("FAIL reset_data got %h/%h exp 0", di_db, dq_db); else n_pass++;
        n_total++; if (ovf_db !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf_db); else n_pass++;
        n_total++; if (rsv_sb !== 1'b1 || cpl_sb !== 4'h0) $display("FAIL reset_sb got %b/%h exp 1/0", rsv_sb, cpl_sb); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_ramp();
        logic [15:0] e;
        send(0, 16, 0);
        capture(0, 10);
        // Last sample taken at edge E; first beat appears at E+2, i.e. one falling edge is skipped.
        n_total++; if (cap_wait !== 1) $display("FAIL ramp_latency got %0d exp 1", cap_wait); else n_pass++;
        n_total++; if (cap_n !== 4) $display("FAIL ramp_beats got %0d exp 4", cap_n); else n_pass++;
        n_total++; if (cap_c[0] !== 8'h0F) $display("FAIL ramp_cpl got %h exp 0f", cap_c[0]); else n_pass++;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                e = 16'(4*c + j);
                n_total++;
                if (cap_d[c][j] !== {e, ~e}) $display("FAIL ramp_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                else n_pass++;
            end
        n_total++; if (ovf_db !== 1'b0) $display("FAIL ramp_ovf got %b exp 0", ovf_db); else n_pass++;
    endtask

    task automatic test_ready_hold();
        logic [15:0] e;
        int early;
        rdy_sb = 4'b0111;
        send(1, 16, 16'h20);
        n_total++; if (rsv_sb !== 1'b0) $display("FAIL hold_rsv_low got %b exp 0", rsv_sb); else n_pass++;
        early = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpl_sb !== 4'h0) early++;
        end
        n_total++; if (early !== 0) $display("FAIL hold_no_cpl got %0d early beats exp 0", early); else n_pass++;
        rdy_sb = 4'hF;
        capture(1, 6);
        n_total++; if (cap_wait !== 1) $display("FAIL hold_start got %0d exp 1", cap_wait); else n_pass++;
        n_total++; if (cap_n !== 4) $display("FAIL hold_beats got %0d exp 4", cap_n); else n_pass++;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                e = 16'(16'h20 + 4*c + j);
                n_total++;
                if (cap_d[c][j] !== {e, ~e}) $display("FAIL hold_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                else n_pass++;
            end
        @(negedge clk);
        n_total++; if (rsv_sb !== 1'b1) $display("FAIL hold_rsv_back got %b exp 1", rsv_sb); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        blocked_seen = 1'b0;
        fork
            send(0, 32, 16'h40);
            begin
                capture(0, 40);
                n_total++; if (cap_n !== 4) $display("FAIL b2b_f1_beats got %0d exp 4", cap_n); else n_pass++;
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++) begin
                        e = 16'(16'h40 + 4*c + j);
                        n_total++;
                        if (cap_d[c][j] !== {e, ~e}) $display("FAIL b2b_f1_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                        else n_pass++;
                    end
                capture(0, 40);
                n_total++; if (cap_n !== 4) $display("FAIL b2b_f2_beats got %0d exp 4", cap_n); else n_pass++;
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++) begin
                        e = 16'(16'h50 + 4*c + j);
                        n_total++;
                        if (cap_d[c][j] !== {e, ~e}) $display("FAIL b2b_f2_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                        else n_pass++;
                    end
            end
        join
        n_total++; if (blocked_seen !== 1'b0) $display("FAIL b2b_rsv got blocked exp always 1"); else n_pass++;
        n_total++; if (ovf_db !== 1'b0) $display("FAIL b2b_ovf got %b exp 0", ovf_db); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] e;
        rdy_sb = 4'h0;
        send(1, 16, 16'h60);
        blocked_seen = 1'b0;
        repeat (2) @(negedge clk);
        send(1, 5, 16'h99);
        n_total++; if (blocked_seen !== 1'b1) $display("FAIL ovf_blocked got %b exp 1", blocked_seen); else n_pass++;
        n_total++; if (rsv_sb !== 1'b0) $display("FAIL ovf_rsv got %b exp 0", rsv_sb); else n_pass++;
        n_total++; if (ovf_sb !== 1'b1) $display("FAIL ovf_set got %b exp 1", ovf_sb); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (ovf_sb !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf_sb); else n_pass++;
        rdy_sb = 4'hF;
        capture(1, 6);
        n_total++; if (cap_wait !== 1 || cap_n !== 4) $display("FAIL ovf_stream got wait %0d beats %0d exp 1/4", cap_wait, cap_n); else n_pass++;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                e = 16'(16'h60 + 4*c + j);
                n_total++;
                if (cap_d[c][j] !== {e, ~e}) $display("FAIL ovf_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                else n_pass++;
            end
        @(negedge clk);
        n_total++; if (rsv_sb !== 1'b1 || ovf_sb !== 1'b1) $display("FAIL ovf_after got rsv %b ovf %b exp 1/1", rsv_sb, ovf_sb); else n_pass++;
        // Dropped samples must not have advanced the write counter.
        send(1, 16, 16'h70);
        capture(1, 6);
        n_total++; if (cap_n !== 4) $display("FAIL ovf_next_beats got %0d exp 4", cap_n); else n_pass++;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                e = 16'(16'h70 + 4*c + j);
                n_total++;
                if (cap_d[c][j] !== {e, ~e}) $display("FAIL ovf_next_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                else n_pass++;
            end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] e;
        send(0, 10, 16'h80);
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (cpl_db !== 4'h0 || di_db !== 64'h0) $display("FAIL mid_rst_out got %h/%h exp 0", cpl_db, di_db); else n_pass++;
        n_total++; if (rsv_db !== 1'b1 || ovf_db !== 1'b0) $display("FAIL mid_rst_flags got %b/%b exp 1/0", rsv_db, ovf_db); else n_pass++;
        n_total++; if (ovf_sb !== 1'b0) $display("FAIL mid_rst_ovf_sb got %b exp 0", ovf_sb); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        send(0, 16, 16'h90);
        capture(0, 6);
        n_total++; if (cap_wait !== 1 || cap_n !== 4) $display("FAIL mid_stream got wait %0d beats %0d exp 1/4", cap_wait, cap_n); else n_pass++;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                e = 16'(16'h90 + 4*c + j);
                n_total++;
                if (cap_d[c][j] !== {e, ~e}) $display("FAIL mid_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                else n_pass++;
            end
        n_total++; if (ovf_db !== 1'b0) $display("FAIL mid_ovf got %b exp 0", ovf_db); else n_pass++;
    endtask

    task automatic test_sweep();
        logic [15:0] e;
        int bad;
        // Two channels of 16 beats.
        send(2, 32, 16'hA0);
        capture(2, 6);
        n_total++; if (cap_wait !== 1 || cap_n !== 16) $display("FAIL sw1_beats got wait %0d beats %0d exp 1/16", cap_wait, cap_n); else n_pass++;
        bad = 0;
        for (int j = 0; j < 16; j++) if (cap_c[j] !== 8'h03) bad++;
        n_total++; if (bad !== 0) $display("FAIL sw1_cpl got %0d bad beats exp 0", bad); else n_pass++;
        for (int c = 0; c < 2; c++)
            for (int j = 0; j < 16; j++) begin
                e = 16'(16'hA0 + 16*c + j);
                n_total++;
                if (cap_d[c][j] !== {e, ~e}) $display("FAIL sw1_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                else n_pass++;
            end
        // Eight channels of 4 beats.
        send(3, 32, 16'hC0);
        capture(3, 6);
        n_total++; if (cap_wait !== 1 || cap_n !== 4) $display("FAIL sw3_beats got wait %0d beats %0d exp 1/4", cap_wait, cap_n); else n_pass++;
        bad = 0;
        for (int j = 0; j < 4; j++) if (cap_c[j] !== 8'hFF) bad++;
        n_total++; if (bad !== 0) $display("FAIL sw3_cpl got %0d bad beats exp 0", bad); else n_pass++;
        for (int c = 0; c < 8; c++)
            for (int j = 0; j < 4; j++) begin
                e = 16'(16'hC0 + 4*c + j);
                n_total++;
                if (cap_d[c][j] !== {e, ~e}) $display("FAIL sw3_ch%0d_b%0d got %h exp %h", c, j, cap_d[c][j], {e, ~e});
                else n_pass++;
            end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_ready_hold();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
